// File: rtl/serial_mux_master.sv
// Bus-side master for a bank of RS232 channels: arbitrates RX drains and host TX
// pushes over the shared per-channel MUX interface, one transaction at a time.
module serial_mux_master #(
    parameter int NUM_CH          = 8,
    parameter int D_W             = 8,
    parameter int PRIORITY_LEVELS = 8,
    parameter int RD_LAT          = 1,
    localparam int PRIO_W         = $clog2(PRIORITY_LEVELS),
    localparam int CH_W           = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*PRIO_W-1:0] ch_priority_rx,
    input  logic [NUM_CH*PRIO_W-1:0] ch_priority_tx,
    input  logic [NUM_CH*D_W-1:0]    ch_data_out,
    input  logic [NUM_CH*4-1:0]      ch_errors,
    output logic [NUM_CH-1:0]        chan_active,
    output logic                     commit_read,
    output logic                     commit_write,
    output logic                     clear_flags,
    output logic [D_W-1:0]           data_in,
    output logic [D_W-1:0]           host_rx_data,
    output logic [CH_W-1:0]          host_rx_chan,
    output logic                     host_rx_valid,
    input  logic                     host_rx_ready,
    input  logic [D_W-1:0]           host_tx_data,
    input  logic [CH_W-1:0]          host_tx_chan,
    input  logic                     host_tx_valid,
    output logic                     host_tx_ready,
    input  logic                     host_clr_req,
    output logic [NUM_CH-1:0]        err_summary
);

    typedef enum logic [2:0] {
        IDLE, WR, CLR, RD_CMD, RD_WAIT, RD_OUT, SETTLE
    } state_t;

    state_t          state, state_nx;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] sel;
    logic [CH_W-1:0] tgt;
    logic            tgt_ok;
    logic [D_W-1:0]  tx_byte;
    logic            last_was_wr;
    logic [1:0]      wait_cnt;

    logic            rd_cand;
    logic [CH_W-1:0] rd_sel;
    logic            tx_in_range;
    logic            tx_full;
    logic            wr_cand;
    logic [D_W-1:0]  rd_byte;

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            if (idx == CH_W'(i)) v[i] = 1'b1;
        return v;
    endfunction

    // Cyclic scan from rr_ptr with strict '>' so the earliest channel wins ties.
    always_comb begin
        logic [PRIO_W-1:0] best;
        int unsigned       idx;
        best    = '0;
        rd_sel  = '0;
        rd_cand = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (ch_priority_rx[idx*PRIO_W +: PRIO_W] > best) begin
                best    = ch_priority_rx[idx*PRIO_W +: PRIO_W];
                rd_sel  = CH_W'(idx);
                rd_cand = 1'b1;
            end
        end
    end

    // Out-of-range targets bypass the full check so the host is never stalled.
    always_comb begin
        tx_in_range = 1'b0;
        tx_full     = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (host_tx_chan == CH_W'(i)) begin
                tx_in_range = 1'b1;
                tx_full     = (ch_priority_tx[i*PRIO_W +: PRIO_W] == PRIO_W'(PRIORITY_LEVELS-1));
            end
        end
        wr_cand = host_tx_valid && (!tx_in_range || !tx_full);
    end

    always_comb begin
        rd_byte = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            if (sel == CH_W'(i)) rd_byte = ch_data_out[i*D_W +: D_W];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (host_clr_req)
                    state_nx = CLR;
                else if (wr_cand && (!rd_cand || !last_was_wr))
                    state_nx = WR;
                else if (rd_cand)
                    state_nx = RD_CMD;
            end
            WR, CLR: state_nx = SETTLE;
            RD_CMD:  state_nx = RD_WAIT;
            RD_WAIT: if (wait_cnt == 2'd0) state_nx = RD_OUT;
            RD_OUT:  if (host_rx_ready) state_nx = SETTLE;
            SETTLE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        chan_active   = '0;
        commit_read   = 1'b0;
        commit_write  = 1'b0;
        clear_flags   = 1'b0;
        data_in       = '0;
        host_tx_ready = 1'b0;
        host_rx_valid = 1'b0;
        case (state)
            WR: begin
                chan_active   = onehot(tgt);
                commit_write  = tgt_ok;
                data_in       = tx_byte;
                host_tx_ready = 1'b1;
            end
            CLR: begin
                chan_active = onehot(tgt);
                clear_flags = tgt_ok;
            end
            RD_CMD: begin
                chan_active = onehot(sel);
                commit_read = 1'b1;
            end
            RD_WAIT: chan_active   = onehot(sel);
            RD_OUT:  host_rx_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            sel          <= '0;
            tgt          <= '0;
            tgt_ok       <= 1'b0;
            tx_byte      <= '0;
            last_was_wr  <= 1'b0;
            wait_cnt     <= '0;
            host_rx_data <= '0;
            host_rx_chan <= '0;
            err_summary  <= '0;
        end else begin
            state <= state_nx;
            for (int unsigned i = 0; i < NUM_CH; i++)
                err_summary[i] <= |ch_errors[i*4 +: 4];
            if (state == IDLE) begin
                tgt     <= host_tx_chan;
                tgt_ok  <= tx_in_range;
                tx_byte <= host_tx_data;
                if (state_nx == RD_CMD) begin
                    sel    <= rd_sel;
                    rr_ptr <= (rd_sel == CH_W'(NUM_CH-1)) ? '0 : rd_sel + 1'b1;
                end
            end
            if (state == WR)
                last_was_wr <= 1'b1;
            if (state == RD_CMD) begin
                last_was_wr <= 1'b0;
                wait_cnt    <= 2'(RD_LAT-1);
            end
            if (state == RD_WAIT) begin
                if (wait_cnt == 2'd0) begin
                    host_rx_data <= rd_byte;
                    host_rx_chan <= sel;
                end else begin
                    wait_cnt <= wait_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_mux_master.sv
// Directed self-checking bench for serial_mux_master with default parameters.
module tb_serial_mux_master;

    localparam int NUM_CH = 8;
    localparam int D_W    = 8;
    localparam int PW     = 3;
    localparam int CW     = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_CH*PW-1:0]   ch_priority_rx;
    logic [NUM_CH*PW-1:0]   ch_priority_tx;
    logic [NUM_CH*D_W-1:0]  ch_data_out;
    logic [NUM_CH*4-1:0]    ch_errors;
    logic [NUM_CH-1:0]      chan_active;
    logic                   commit_read, commit_write, clear_flags;
    logic [D_W-1:0]         data_in;
    logic [D_W-1:0]         host_rx_data;
    logic [CW-1:0]          host_rx_chan;
    logic                   host_rx_valid, host_rx_ready;
    logic [D_W-1:0]         host_tx_data;
    logic [CW-1:0]          host_tx_chan;
    logic                   host_tx_valid, host_tx_ready, host_clr_req;
    logic [NUM_CH-1:0]      err_summary;

    int checks   = 0;
    int failures = 0;

    serial_mux_master #(.NUM_CH(NUM_CH), .D_W(D_W), .PRIORITY_LEVELS(8), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .ch_priority_rx(ch_priority_rx), .ch_priority_tx(ch_priority_tx),
        .ch_data_out(ch_data_out), .ch_errors(ch_errors),
        .chan_active(chan_active), .commit_read(commit_read),
        .commit_write(commit_write), .clear_flags(clear_flags),
        .data_in(data_in), .host_rx_data(host_rx_data), .host_rx_chan(host_rx_chan),
        .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
        .host_tx_data(host_tx_data), .host_tx_chan(host_tx_chan),
        .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
        .host_clr_req(host_clr_req), .err_summary(err_summary)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input int ch, input int v);
        ch_priority_rx[ch*PW +: PW] = PW'(v);
    endtask

    // Called in an IDLE cycle where ch is the expected winner; returns in IDLE.
    task automatic do_read(input int ch, input logic [7:0] d);
        tick;
        chk("rd_cmd_strobe", 32'(commit_read), 32'd1);
        chk("rd_cmd_chan", 32'(chan_active), 32'd1 << ch);
        tick;
        chk("rd_wait_strobe", 32'(commit_read), 32'd0);
        chk("rd_wait_chan", 32'(chan_active), 32'd1 << ch);
        chk("rd_wait_valid", 32'(host_rx_valid), 32'd0);
        tick;
        chk("rd_out_valid", 32'(host_rx_valid), 32'd1);
        chk("rd_out_data", 32'(host_rx_data), 32'(d));
        chk("rd_out_src", 32'(host_rx_chan), 32'(ch));
        chk("rd_out_chan", 32'(chan_active), 32'd0);
        tick;
        chk("settle_valid", 32'(host_rx_valid), 32'd0);
        chk("settle_chan", 32'(chan_active), 32'd0);
        tick;
    endtask

    initial begin
        rst = 1'b1;
        ch_priority_rx = '0;
        ch_priority_tx = '0;
        ch_errors      = '0;
        host_rx_ready  = 1'b1;
        host_tx_data   = '0;
        host_tx_chan   = '0;
        host_tx_valid  = 1'b0;
        host_clr_req   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) ch_data_out[i*D_W +: D_W] = 8'(8'h11 * i);
        ch_data_out[3*D_W +: D_W] = 8'hA5;
        ch_data_out[0 +: D_W]     = 8'hC3;

        tick; tick;
        chk("rst_chan", 32'(chan_active), 32'd0);
        chk("rst_strobes", 32'({commit_read, commit_write, clear_flags}), 32'd0);
        chk("rst_valid", 32'(host_rx_valid), 32'd0);
        chk("rst_tx_ready", 32'(host_tx_ready), 32'd0);
        chk("rst_err", 32'(err_summary), 32'd0);
        chk("rst_rx_data", 32'(host_rx_data), 32'd0);
        rst = 1'b0;
        tick;
        chk("idle_quiet", 32'({commit_read, commit_write, clear_flags}), 32'd0);

        // RX drain of ch3
        set_rx(3, 2);
        do_read(3, 8'hA5);
        set_rx(3, 0);

        // Tie round-robin; rr_ptr is 4 after the ch3 read, so ch5 goes first
        set_rx(1, 4); set_rx(5, 4);
        do_read(5, 8'h55);
        do_read(1, 8'h11);
        do_read(5, 8'h55);
        do_read(1, 8'h11);
        set_rx(1, 0); set_rx(5, 0);

        // Higher level beats round-robin position
        set_rx(6, 5); set_rx(2, 3);
        do_read(6, 8'h66);
        set_rx(6, 0);
        do_read(2, 8'h22);
        set_rx(2, 0);

        // TX into ch2
        host_tx_valid = 1'b1; host_tx_chan = 3'd2; host_tx_data = 8'h3C;
        tick;
        chk("wr_strobe", 32'(commit_write), 32'd1);
        chk("wr_chan", 32'(chan_active), 32'h04);
        chk("wr_data", 32'(data_in), 32'h3C);
        chk("wr_ready", 32'(host_tx_ready), 32'd1);
        host_tx_valid = 1'b0;
        tick;
        chk("wr_settle", 32'({commit_write, host_tx_ready}), 32'd0);
        tick;

        // TX blocked while ch2 full
        ch_priority_tx[2*PW +: PW] = 3'd7;
        host_tx_valid = 1'b1; host_tx_data = 8'h3D;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("full_no_ready", 32'(host_tx_ready), 32'd0);
            chk("full_no_write", 32'(commit_write), 32'd0);
        end
        ch_priority_tx[2*PW +: PW] = 3'd0;
        tick;
        chk("unfull_wr", 32'(commit_write), 32'd1);
        chk("unfull_data", 32'(data_in), 32'h3D);
        host_tx_valid = 1'b0;
        tick; tick;

        // Mixed load: last was WR so read first, then alternate
        host_tx_valid = 1'b1; host_tx_chan = 3'd0; host_tx_data = 8'h5A;
        set_rx(7, 1);
        do_read(7, 8'h77);
        tick;
        chk("mix_wr_strobe", 32'(commit_write), 32'd1);
        chk("mix_wr_chan", 32'(chan_active), 32'h01);
        chk("mix_wr_data", 32'(data_in), 32'h5A);
        tick;
        chk("mix_settle", 32'({commit_read, commit_write}), 32'd0);
        tick;
        do_read(7, 8'h77);
        tick;
        chk("mix_wr2_strobe", 32'(commit_write), 32'd1);
        host_tx_valid = 1'b0;
        set_rx(7, 0);
        tick; tick;

        // Backpressure on host RX
        host_rx_ready = 1'b0;
        set_rx(0, 3);
        tick;
        chk("bp_cmd", 32'(chan_active), 32'h01);
        tick; tick;
        chk("bp_valid", 32'(host_rx_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("bp_hold_valid", 32'(host_rx_valid), 32'd1);
            chk("bp_hold_data", 32'(host_rx_data), 32'hC3);
            chk("bp_hold_src", 32'(host_rx_chan), 32'd0);
            chk("bp_no_read", 32'(commit_read), 32'd0);
        end
        host_rx_ready = 1'b1;
        tick;
        chk("bp_release", 32'(host_rx_valid), 32'd0);
        set_rx(0, 0);
        tick; tick;
        chk("bp_idle", 32'(commit_read), 32'd0);

        // Error summary and clear
        ch_errors[4*4 +: 4] = 4'b0010;
        chk("err_latency", 32'(err_summary), 32'd0);
        tick;
        chk("err_summary", 32'(err_summary), 32'h10);
        host_clr_req = 1'b1; host_tx_chan = 3'd4;
        tick;
        chk("clr_strobe", 32'(clear_flags), 32'd1);
        chk("clr_chan", 32'(chan_active), 32'h10);
        chk("clr_no_ready", 32'(host_tx_ready), 32'd0);
        host_clr_req = 1'b0;
        tick;
        chk("clr_settle", 32'(clear_flags), 32'd0);
        tick;

        // Reset during RD_WAIT
        set_rx(2, 1);
        tick;
        chk("rstw_cmd", 32'(chan_active), 32'h04);
        tick;
        chk("rstw_wait", 32'(chan_active), 32'h04);
        rst = 1'b1;
        #1;
        chk("rstw_chan", 32'(chan_active), 32'd0);
        chk("rstw_strobes", 32'({commit_read, commit_write, clear_flags}), 32'd0);
        chk("rstw_valid", 32'(host_rx_valid), 32'd0);
        chk("rstw_data", 32'(host_rx_data), 32'd0);
        set_rx(2, 0);
        tick;
        rst = 1'b0;
        tick;
        chk("rstw_after", 32'({host_rx_valid, commit_read}), 32'd0);
        set_rx(5, 2);
        do_read(5, 8'h55);
        set_rx(5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
